// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a STATUS/TXDATA register pair in front of a
// small byte FIFO feeding a registered-output serializer.
module uart_tx_mmio #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        serial_out,
    output logic [1:0]  dbg_state_o
);
    localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int BW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [29:0]   ADDR_STATUS = 30'h2000_0000;
    localparam logic [29:0]   ADDR_TXDATA = 30'h2000_0002;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          ovf_q, ovf_d;
    logic [29:0]   addr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic push_req, push, pop, tx_ready, tx_idle;

    assign tx_ready = (count_q < DEPTH_C);
    assign tx_idle  = (count_q == '0) && (state_q == S_IDLE);
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign push_req = we && (addr == ADDR_TXDATA);
    // A full FIFO still takes a byte when the serializer frees a slot this cycle.
    assign push     = push_req && (tx_ready || pop);

    always_comb begin
        ovf_d = ovf_q;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (we && (addr == ADDR_STATUS) && wdata[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (addr_q == ADDR_STATUS) begin
            rdata = {29'd0, ovf_q, tx_idle, tx_ready};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            addr_q <= addr;
            ovf_q  <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is decoded from the next state so the pin register matches the state register.
        case (state_d)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_d[bit_d];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
        end
    end

    assign serial_out  = serial_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: 8 clocks per bit, 8-entry FIFO, serial line decoded
// independently and compared against the queue of bytes software should see.
module tb_uart_tx_mmio;
  localparam int TB_CLOCK_FREQ = 8;
  localparam int TB_BAUD_RATE  = 1;
  localparam int TB_DEPTH      = 8;
  localparam int CPB           = TB_CLOCK_FREQ / TB_BAUD_RATE;
  localparam int FRAME_CYC     = 10 * CPB + 1;

  localparam logic [29:0] A_STATUS = 30'h2000_0000;
  localparam logic [29:0] A_TXDATA = 30'h2000_0002;

  logic        clk;
  logic        rst;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        serial_out;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_mmio #(
    .CLOCK_FREQ(TB_CLOCK_FREQ),
    .BAUD_RATE (TB_BAUD_RATE),
    .FIFO_DEPTH(TB_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .we         (we),
    .wdata      (wdata),
    .rdata      (rdata),
    .serial_out (serial_out),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: finds a start bit, samples every bit at mid-period, and
  // compares the recovered byte with the oldest expected byte.
  initial begin : line_monitor
    logic [7:0] b;
    logic       ok;
    logic       aborted;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && serial_out === 1'b0) begin
        start_q.push_back(cyc);
        b = 8'h00;
        ok = 1'b1;
        aborted = 1'b0;
        for (int c = 1; c <= 9 * CPB + CPB / 2; c++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) begin
            if (c / CPB == 0 && serial_out !== 1'b0) ok = 1'b0;
            else if (c / CPB >= 1 && c / CPB <= 8) b[c / CPB - 1] = serial_out;
            else if (c / CPB == 9 && serial_out !== 1'b1) ok = 1'b0;
          end
        end
        if (!aborted) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL line_frame: unexpected frame byte=%02h", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e || !ok) begin
              failures++;
              $display("FAIL line_frame: got byte=%02h framing_ok=%0b, expected byte=%02h framing_ok=1", b, ok, e);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic do_write(input logic [29:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = A_STATUS;
    we = 1'b0;
    @(posedge clk);
    #1;
    v = rdata;
  endtask

  task automatic wait_drain(input string tag);
    logic [31:0] v;
    int n;
    n = 0;
    read_status(v);
    while (!(exp_q.size() == 0 && v[1] === 1'b1) && n < 3000) begin
      read_status(v);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || v[1] !== 1'b1) begin
      failures++;
      $display("FAIL drain_%s: pending=%0d idle=%0b, expected pending=0 idle=1", tag, exp_q.size(), v[1]);
    end
  endtask

  // scenarios
  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    we = 1'b0;
    addr = 30'd0;
    wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (serial_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_line: got %0b, expected 1", serial_out);
    end
    checks++;
    if (rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_rdata: got %08h, expected 00000000", rdata);
    end
    rst = 1'b0;
    read_status(v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL reset_status: got %08h, expected 00000003", v);
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    do_write(A_TXDATA, {24'd0, b});
    exp_q.push_back(b);
    addr = A_STATUS;
    checks++;
    if (serial_out !== 1'b1) begin
      failures++;
      $display("FAIL single_pre_start: got %0b, expected 1", serial_out);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 10 * CPB; i++) begin
      checks++;
      if (serial_out !== frame[i / CPB]) begin
        failures++;
        $display("FAIL single_line byte=%02h cycle=%0d: got %0b, expected %0b", b, i, serial_out, frame[i / CPB]);
      end
      checks++;
      if (rdata[1] !== 1'b0) begin
        failures++;
        $display("FAIL single_busy cycle=%0d: tx_idle got %0b, expected 0", i, rdata[1]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (rdata !== 32'h3 || serial_out !== 1'b1) begin
      failures++;
      $display("FAIL single_done: status=%08h line=%0b, expected status=00000003 line=1", rdata, serial_out);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    start_q.delete();
    for (int i = 0; i < 10; i++) begin
      do_write(A_TXDATA, 32'h41 + i);
      if (i < 9) exp_q.push_back(8'(8'h41 + i));
    end
    read_status(v);
    checks++;
    if (v !== 32'h4) begin
      failures++;
      $display("FAIL overflow_status: got %08h, expected 00000004", v);
    end
  endtask

  task automatic test_overflow_clear();
    logic [31:0] v;
    do_write(A_STATUS, 32'h3);
    read_status(v);
    checks++;
    if (v !== 32'h4) begin
      failures++;
      $display("FAIL ovf_keep_bit2_0: got %08h, expected 00000004", v);
    end
    do_write(A_STATUS, 32'h4);
    read_status(v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL ovf_clear: got %08h, expected 00000000", v);
    end
    do_write(A_TXDATA, 32'h5A);
    read_status(v);
    checks++;
    if (v !== 32'h4) begin
      failures++;
      $display("FAIL ovf_reset_by_drop: got %08h, expected 00000004", v);
    end
    wait_drain("overflow");
    checks++;
    if (start_q.size() != 9) begin
      failures++;
      $display("FAIL overflow_frames: got %0d frames, expected 9", start_q.size());
    end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i - 1] != FRAME_CYC) begin
        failures++;
        $display("FAIL frame_gap %0d: got %0d cycles, expected %0d", i, start_q[i] - start_q[i - 1], FRAME_CYC);
      end
    end
    read_status(v);
    checks++;
    if (v !== 32'h7) begin
      failures++;
      $display("FAIL overflow_sticky: got %08h, expected 00000007", v);
    end
    do_write(A_STATUS, 32'h4);
    read_status(v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL overflow_final_clear: got %08h, expected 00000003", v);
    end
  endtask

  task automatic send_polled(input logic [7:0] b);
    logic [31:0] v;
    int n;
    n = 0;
    read_status(v);
    while (v[0] !== 1'b1 && n < 2000) begin
      read_status(v);
      n++;
    end
    checks++;
    if (v[0] !== 1'b1) begin
      failures++;
      $display("FAIL poll_ready: tx_ready got %0b, expected 1", v[0]);
    end else begin
      do_write(A_TXDATA, {24'd0, b});
      exp_q.push_back(b);
    end
  endtask

  task automatic test_boot_prompt();
    logic [7:0] prompt [4];
    logic [31:0] v;
    prompt[0] = 8'h3E;
    prompt[1] = 8'h30;
    prompt[2] = 8'h35;
    prompt[3] = 8'h31;
    for (int i = 0; i < 4; i++) send_polled(prompt[i]);
    for (int i = 0; i < 12; i++) send_polled(8'($urandom_range(0, 255)));
    wait_drain("boot");
    read_status(v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL boot_status: got %08h, expected 00000003", v);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b0;
    logic [31:0] v;
    int lows;
    b0 = 8'($urandom_range(0, 255));
    do_write(A_TXDATA, {24'd0, b0});
    do_write(A_TXDATA, 32'($urandom_range(0, 255)));
    do_write(A_TXDATA, 32'($urandom_range(0, 255)));
    repeat (34) @(posedge clk);
    #1;
    checks++;
    if (serial_out !== b0[3]) begin
      failures++;
      $display("FAIL midframe_bit3: got %0b, expected %0b", serial_out, b0[3]);
    end
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (serial_out !== 1'b1 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL midframe_reset: line=%0b rdata=%08h, expected line=1 rdata=00000000", serial_out, rdata);
    end
    rst = 1'b0;
    addr = A_STATUS;
    lows = 0;
    repeat (3 * FRAME_CYC) begin
      @(posedge clk);
      #1;
      if (serial_out !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL midframe_quiet: got %0d low cycles, expected 0", lows);
    end
    read_status(v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL midframe_status: got %08h, expected 00000003", v);
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h3E);
    test_single(8'($urandom_range(0, 255)));
    test_overflow();
    test_overflow_clear();
    test_boot_prompt();
    test_reset_midframe();
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, at byte base 0x8000_0000. Software polls a status word and writes bytes to a TX data word. Bytes queue in a small FIFO and are serialized as 8N1, LSB first, on the serial_out pin. Read timing matches the boot ROM: the address is registered, and read data is valid the cycle after the address is presented.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate
FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, at least 2
CLOCKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (derived, integer division), clocks per serial bit

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
addr  input  30  word address (byte address >> 2)
we  input  1  write strobe; one write per cycle when high
wdata  input  32  write data
rdata  output  32  read data for the address registered on the previous edge
serial_out  output  1  UART TX line; idles high

Behaviour:
- Register map (word addresses):
  - 0x2000_0000 is STATUS.
    - Read: bit0 = tx_ready (fifo_count < FIFO_DEPTH).
    - Read: bit1 = tx_idle (FIFO empty and serializer in IDLE).
    - Read: bit2 = overflow (sticky). Other bits read 0.
  - 0x2000_0002 is TXDATA. Write pushes wdata[7:0]. Reads return 0.
  - Any other address: reads return 0 and writes are ignored.
- Read path:
  - addr_r <= rst ? 0 : addr.
  - rdata is combinational from addr_r and the current status.
  - Result: latency is 1 cycle, and the returned status reflects the state in that following cycle.
- Write path:
  - A TXDATA write is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - A STATUS write with wdata[2]=1 clears overflow. If a dropped push occurs in the same cycle, set wins.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Count range is 0..FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - Simultaneous push and pop on an empty FIFO is impossible, because a pop requires count > 0 at the start of the cycle.
- Serializer FSM:
  - States are IDLE, START, DATA, STOP.
  - A bit counter (0..7) and a baud counter (0..CLOCKS_PER_BIT-1) advance the FSM.
  - IDLE:
    - serial_out = 1.
    - If count > 0: pop the head byte into the shift register and go to START. This is the cycle after the push is visible.
  - START: serial_out = 0 for CLOCKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: serial_out = shift[bit] for CLOCKS_PER_BIT cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP:
    - serial_out = 1 for CLOCKS_PER_BIT cycles, then go to IDLE.
    - IDLE may pop again on the next cycle, so back-to-back frames are separated by exactly 1 idle cycle.
  - serial_out is driven from a register, so it is glitch-free.
- Reset, including mid-frame:
  - FIFO is flushed: pointers and count go to 0.
  - overflow = 0.
  - FSM returns to IDLE with all counters at 0.
  - serial_out = 1 on the cycle after the reset edge.
  - addr_r = 0, so rdata = 0.
  - Any partial frame is abandoned.
- Reads have no side effects.

Test Plan:
- Reset: hold rst 2 cycles -> serial_out=1, rdata=0. Read STATUS -> rdata=0x0000_0003 one cycle later.
- Single byte, bench CLOCK_FREQ=8, BAUD_RATE=1 (CLOCKS_PER_BIT=8): write TXDATA=0x3E -> serial_out shows:
  - start 0 for 8 cycles;
  - data 0,1,1,1,1,1,0,0 at 8 cycles each;
  - stop 1 for 8 cycles.
  - STATUS bit1 reads 0 during the frame and 1 after the stop bit.
- Overflow, FIFO_DEPTH=8: 10 back-to-back TXDATA writes 0x41..0x4A starting while idle ->
  - 0x41..0x49 are accepted and 0x4A is dropped;
  - STATUS = 0x4 (ready=0, overflow=1);
  - the line carries 0x41..0x49 in order, with 1 idle cycle between frames.
- Overflow clear: write STATUS wdata=0x4 -> bit2 reads 0. A dropped push in the same cycle -> bit2 stays 1.
- Boot-prompt flow: poll STATUS bit0, then write 0x3E,0x30,0x35,0x31 -> four frames ">051" decoded in order, no loss.
- Reset mid-frame: assert rst during DATA bit 3 of a frame with 2 bytes queued -> serial_out=1 next cycle, no further frames, STATUS reads 0x3 afterwards.
